stopwatch_param_dp: RTL and testbench

STOPWATCH_PARAM_DP -- requirements
Module: stopwatch_param_dp

---
 rtl/stopwatch_param_dp.sv | 199 +++++++++++++++++++
 tb/tb_stopwatch_param_dp.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_param_dp.sv
// stopwatch_param_dp -- cascaded BCD stopwatch / countdown timer.
//
// Optional feature: define STOPWATCH_LAP_EN to build the lap capture
// registers. Without it the lap input is ignored and the lap outputs are
// tied to zero.
//
// Parameters
//   NUM_DIGITS : number of BCD digits (1-8)
//   DIGIT_MAX  : per-digit maximum, digit i in bits [4i+3:4i], each 1-9
//   SATURATE   : 0 = up-count wraps at full scale, 1 = holds and expires
// Ports
//   clk, rst (async, active-low)
//   enable     : count tick qualifier while running
//   up_down    : 1 = count up, 0 = count down
//   start/stop/clear/load : control strobes, priority clear > load > stop > start
//   load_value : preset digits, clamped per field to DIGIT_MAX
//   lap        : lap capture strobe
//   digits     : current count
//   lap_digits, lap_valid : captured lap value and its valid flag
//   running, expired      : state decode
//   rollover   : one-cycle pulse on an up-count wrap to zero
module stopwatch_param_dp #(
  parameter int unsigned               NUM_DIGITS = 6,
  parameter logic [4*NUM_DIGITS-1:0]   DIGIT_MAX  = 24'h595999,
  parameter bit                        SATURATE   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [4*NUM_DIGITS-1:0] lap_digits,
  output logic                    lap_valid,
  output logic                    running,
  output logic                    expired,
  output logic                    rollover
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_EXPIRED
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   digits_q, digits_d;
  logic           rollover_q, rollover_d;

  logic [W-1:0]   inc_val, dec_val, clamp_val;
  logic           inc_carry, dec_borrow;
  logic           do_tick;

  // Ripple carry/borrow across digits. A carry left over after the top
  // digit means every digit was at its max; a leftover borrow means all zero.
  always_comb begin
    inc_val    = digits_q;
    dec_val    = digits_q;
    clamp_val  = load_value;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (inc_carry) begin
        if (digits_q[4*i +: 4] == DIGIT_MAX[4*i +: 4]) begin
          inc_val[4*i +: 4] = '0;
        end else begin
          inc_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (digits_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = DIGIT_MAX[4*i +: 4];
        end else begin
          dec_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
      if (load_value[4*i +: 4] > DIGIT_MAX[4*i +: 4]) begin
        clamp_val[4*i +: 4] = DIGIT_MAX[4*i +: 4];
      end
    end
  end

  // Only the highest-priority asserted strobe is considered; if that strobe
  // is ignored in the current state, lower strobes still do not act.
  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    rollover_d = 1'b0;
    do_tick    = (state_q == S_RUN) && enable;

    if (clear) begin
      state_d  = S_IDLE;
      digits_d = '0;
      do_tick  = 1'b0;
    end else if (load) begin
      if (state_q == S_IDLE || state_q == S_PAUSE) begin
        digits_d = clamp_val;
      end
    end else if (stop) begin
      if (state_q == S_RUN) begin
        state_d = S_PAUSE;
        do_tick = 1'b0;
      end
    end else if (start) begin
      if (state_q == S_IDLE || state_q == S_PAUSE) begin
        state_d = S_RUN;
      end
    end

    if (do_tick) begin
      if (up_down) begin
        if (inc_carry) begin
          if (SATURATE) begin
            state_d = S_EXPIRED;
          end else begin
            digits_d   = '0;
            rollover_d = 1'b1;
          end
        end else begin
          digits_d = inc_val;
        end
      end else begin
        if (dec_borrow) begin
          state_d = S_EXPIRED;
        end else begin
          digits_d = dec_val;
          if (dec_val == '0) begin
            state_d = S_EXPIRED;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      digits_q   <= '0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      rollover_q <= rollover_d;
    end
  end

  assign digits   = digits_q;
  assign rollover = rollover_q;
  assign running  = (state_q == S_RUN);
  assign expired  = (state_q == S_EXPIRED);

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] lap_digits_q, lap_digits_d;
  logic         lap_valid_q, lap_valid_d;

  // Captures the pre-tick count, so a lap coincident with a tick sees the
  // value before the increment.
  always_comb begin
    lap_digits_d = lap_digits_q;
    lap_valid_d  = lap_valid_q;
    if (clear) begin
      lap_digits_d = '0;
      lap_valid_d  = 1'b0;
    end else if (lap && (state_q == S_RUN || state_q == S_PAUSE)) begin
      lap_digits_d = digits_q;
      lap_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_digits_q <= '0;
      lap_valid_q  <= 1'b0;
    end else begin
      lap_digits_q <= lap_digits_d;
      lap_valid_q  <= lap_valid_d;
    end
  end

  assign lap_digits = lap_digits_q;
  assign lap_valid  = lap_valid_q;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign lap_digits = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_param_dp.sv
// Testbench for stopwatch_param_dp: a wrapping instance and a saturating
// instance share all inputs and are compared every cycle against an
// integer (mixed-radix) reference model, plus directed scenario checks.
module tb_stopwatch_param_dp;

  localparam logic [23:0] DMAX = 24'h595999;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, up_down, start, stop, clear, load, lap;
  logic [23:0] load_value;

  logic [23:0] d0_digits, d0_lap, d1_digits, d1_lap;
  logic        d0_lapv, d0_run, d0_exp, d0_roll;
  logic        d1_lapv, d1_run, d1_exp, d1_roll;

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = wrapping, 1 = saturating
  int m_st  [2];
  int m_val [2];
  int m_lap [2];
  bit m_lapv[2];
  bit m_roll[2];
  int full_sc;

  always #5 clk = ~clk;

  stopwatch_param_dp #(.NUM_DIGITS(6), .DIGIT_MAX(DMAX), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down),
    .start(start), .stop(stop), .clear(clear), .load(load),
    .load_value(load_value), .lap(lap),
    .digits(d0_digits), .lap_digits(d0_lap), .lap_valid(d0_lapv),
    .running(d0_run), .expired(d0_exp), .rollover(d0_roll)
  );

  stopwatch_param_dp #(.NUM_DIGITS(6), .DIGIT_MAX(DMAX), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down),
    .start(start), .stop(stop), .clear(clear), .load(load),
    .load_value(load_value), .lap(lap),
    .digits(d1_digits), .lap_digits(d1_lap), .lap_valid(d1_lapv),
    .running(d1_run), .expired(d1_exp), .rollover(d1_roll)
  );

  function automatic int calc_full();
    logic [23:0] mx;
    int p;
    mx = DMAX;
    p  = 1;
    for (int i = 0; i < 6; i++) p = p * (int'(mx[4*i +: 4]) + 1);
    return p - 1;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] mx, r;
    int rem, rad;
    mx  = DMAX;
    r   = '0;
    rem = v;
    for (int i = 0; i < 6; i++) begin
      rad = int'(mx[4*i +: 4]) + 1;
      r[4*i +: 4] = 4'(rem % rad);
      rem = rem / rad;
    end
    return r;
  endfunction

  function automatic int clamp_to_int(input logic [23:0] x);
    logic [23:0] mx;
    int v, w, f, m;
    mx = DMAX;
    v  = 0;
    w  = 1;
    for (int i = 0; i < 6; i++) begin
      f = int'(x[4*i +: 4]);
      m = int'(mx[4*i +: 4]);
      if (f > m) f = m;
      v = v + f * w;
      w = w * (m + 1);
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_IDLE; m_val[k] = 0; m_lap[k] = 0; m_lapv[k] = 1'b0; m_roll[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k);
    bit tick;
    tick = (m_st[k] == M_RUN) && enable;
    m_roll[k] = 1'b0;
    if (clear) begin
      m_st[k] = M_IDLE; m_val[k] = 0; m_lap[k] = 0; m_lapv[k] = 1'b0;
    end else begin
      if (LAP_EN && lap && (m_st[k] == M_RUN || m_st[k] == M_PAUSE)) begin
        m_lap[k] = m_val[k]; m_lapv[k] = 1'b1;
      end
      if (load) begin
        if (m_st[k] == M_IDLE || m_st[k] == M_PAUSE) m_val[k] = clamp_to_int(load_value);
      end else if (stop) begin
        if (m_st[k] == M_RUN) begin m_st[k] = M_PAUSE; tick = 1'b0; end
      end else if (start) begin
        if (m_st[k] == M_IDLE || m_st[k] == M_PAUSE) m_st[k] = M_RUN;
      end
      if (tick) begin
        if (up_down) begin
          if (m_val[k] == full_sc) begin
            if (k == 1) m_st[k] = M_EXP;
            else begin m_val[k] = 0; m_roll[k] = 1'b1; end
          end else m_val[k] = m_val[k] + 1;
        end else begin
          if (m_val[k] == 0) m_st[k] = M_EXP;
          else begin
            m_val[k] = m_val[k] - 1;
            if (m_val[k] == 0) m_st[k] = M_EXP;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("d0_digits",    32'(d0_digits), 32'(to_bcd(m_val[0])));
    chk("d0_lap_digits",32'(d0_lap),    32'(to_bcd(m_lap[0])));
    chk("d0_lap_valid", 32'(d0_lapv),   32'(m_lapv[0]));
    chk("d0_running",   32'(d0_run),    32'(m_st[0] == M_RUN));
    chk("d0_expired",   32'(d0_exp),    32'(m_st[0] == M_EXP));
    chk("d0_rollover",  32'(d0_roll),   32'(m_roll[0]));
    chk("d1_digits",    32'(d1_digits), 32'(to_bcd(m_val[1])));
    chk("d1_lap_digits",32'(d1_lap),    32'(to_bcd(m_lap[1])));
    chk("d1_lap_valid", 32'(d1_lapv),   32'(m_lapv[1]));
    chk("d1_running",   32'(d1_run),    32'(m_st[1] == M_RUN));
    chk("d1_expired",   32'(d1_exp),    32'(m_st[1] == M_EXP));
    chk("d1_rollover",  32'(d1_roll),   32'(m_roll[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  task automatic quiet();
    start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; lap = 1'b0;
  endtask

  initial begin
    full_sc    = calc_full();
    rst        = 1'b0;
    enable     = 1'b0;
    up_down    = 1'b1;
    load_value = '0;
    quiet();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("reset_digits", 32'(d0_digits), 32'h0);
    rst = 1'b1;

    // load clamping in IDLE
    load = 1'b1; load_value = 24'h7A9999;
    step();
    chk("clamp_digits", 32'(d0_digits), 32'h595999);
    quiet(); clear = 1'b1;
    step();

    // up-count wrap / saturation at full scale
    quiet(); up_down = 1'b1; load = 1'b1; load_value = 24'h595998;
    step();
    quiet(); start = 1'b1;
    step();
    quiet(); enable = 1'b1;
    step();
    chk("wrap_tick1_digits", 32'(d0_digits), 32'h595999);
    step();
    chk("wrap_tick2_digits", 32'(d0_digits), 32'h000000);
    chk("wrap_rollover",     32'(d0_roll),   32'h1);
    chk("sat_hold_digits",   32'(d1_digits), 32'h595999);
    chk("sat_expired",       32'(d1_exp),    32'h1);
    enable = 1'b0;
    step();
    chk("rollover_one_cycle", 32'(d0_roll), 32'h0);
    clear = 1'b1;
    step();

    // countdown expiry
    quiet(); up_down = 1'b0; load = 1'b1; load_value = 24'h000010;
    step();
    quiet(); start = 1'b1;
    step();
    quiet(); enable = 1'b1;
    repeat (10) step();
    chk("down_digits",  32'(d0_digits), 32'h0);
    chk("down_expired", 32'(d0_exp),    32'h1);
    chk("down_running", 32'(d0_run),    32'h0);
    repeat (2) step();
    chk("down_hold_digits", 32'(d0_digits), 32'h0);
    enable = 1'b0; clear = 1'b1;
    step();

    // lap coincident with a tick
    quiet(); up_down = 1'b1; load = 1'b1; load_value = 24'h000042;
    step();
    quiet(); start = 1'b1;
    step();
    quiet(); enable = 1'b1; lap = 1'b1;
    step();
    chk("lap_tick_digits", 32'(d0_digits), 32'h000043);
    chk("lap_digits",      32'(d0_lap),    LAP_EN ? 32'h000042 : 32'h0);
    chk("lap_valid",       32'(d0_lapv),   32'(LAP_EN));
    lap = 1'b0; enable = 1'b0;

    // clear+load+start while running
    clear = 1'b1; load = 1'b1; start = 1'b1; load_value = 24'h123456;
    step();
    chk("prio_running",   32'(d0_run),    32'h0);
    chk("prio_digits",    32'(d0_digits), 32'h0);
    chk("prio_lap_valid", 32'(d0_lapv),   32'h0);

    // stop coincident with a tick
    quiet(); start = 1'b1;
    step();
    quiet(); enable = 1'b1;
    step();
    stop = 1'b1;
    step();
    chk("stop_tick_digits",  32'(d0_digits), 32'h000001);
    chk("stop_tick_running", 32'(d0_run),    32'h0);
    quiet(); enable = 1'b0; clear = 1'b1;
    step();

    // randomized phase
    for (int n = 0; n < 400; n++) begin
      clear      = ($urandom_range(99) < 3);
      load       = ($urandom_range(99) < 6);
      stop       = ($urandom_range(99) < 5);
      start      = ($urandom_range(99) < 12);
      lap        = ($urandom_range(99) < 10);
      enable     = ($urandom_range(99) < 75);
      if ($urandom_range(99) < 6) up_down = ~up_down;
      load_value = 24'($urandom);
      step();
    end

    // asynchronous reset in the middle of a run
    quiet(); clear = 1'b1; enable = 1'b0;
    step();
    quiet(); up_down = 1'b1; start = 1'b1;
    step();
    quiet(); enable = 1'b1; lap = 1'b1;
    repeat (3) step();
    quiet();
    #3 rst = 1'b0;
    #1;
    chk("rst_d0_digits",   32'(d0_digits), 32'h0);
    chk("rst_d0_lap",      32'(d0_lap),    32'h0);
    chk("rst_d0_lapv",     32'(d0_lapv),   32'h0);
    chk("rst_d0_running",  32'(d0_run),    32'h0);
    chk("rst_d0_expired",  32'(d0_exp),    32'h0);
    chk("rst_d0_rollover", 32'(d0_roll),   32'h0);
    chk("rst_d1_digits",   32'(d1_digits), 32'h0);
    chk("rst_d1_running",  32'(d1_run),    32'h0);
    model_reset();
    #2 rst = 1'b1;
    enable = 1'b0; start = 1'b1;
    step();
    chk("post_rst_start", 32'(d0_run), 32'h1);
    quiet(); enable = 1'b1;
    step();
    chk("post_rst_count", 32'(d0_digits), 32'h000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
